framebuf_pp: RTL

Parametrised ping-pong frame buffer for the image-processing pipeline, successor to the single-bank frame buffer. Two frame banks allow the upstream stage to fill one frame while the downstream stage drains the other. Both sides use req/ack handshakes with mid-frame stalls. Image size, channel count and channel width are configurable.

---
 rtl/framebuf_pkg.sv | 30 +++
 rtl/framebuf_pp_mem.sv | 32 +++
 rtl/framebuf_pp.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/framebuf_pkg.sv
// Shared state encodings, default geometry and address helpers
// for the ping-pong frame buffer.
package framebuf_pkg;

   typedef enum logic [1:0] {
      RX_IDLE   = 2'd0,
      RX_ACTIVE = 2'd1,
      RX_DONE   = 2'd2
   } rx_state_e;

   typedef enum logic [1:0] {
      TX_IDLE   = 2'd0,
      TX_ACTIVE = 2'd1,
      TX_DONE   = 2'd2
   } tx_state_e;

   localparam int DEF_IMG_W    = 128;
   localparam int DEF_IMG_H    = 128;
   localparam int DEF_CHANNELS = 3;
   localparam int DEF_PIX_W    = 8;

   // Raster index -> same line, column reversed.
   function automatic int unsigned mirror_idx(
      input int unsigned idx,
      input int unsigned w
   );
      return (idx / w) * w + (w - 1 - (idx % w));
   endfunction

endpackage

// File: rtl/framebuf_pp_mem.sv
// Simple dual-port frame store: one write port, one registered read port.
// Address is {bank, pixel}.
module framebuf_pp_mem #(
   parameter int AW = 15,
   parameter int DW = 24
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic          re_i,
   input  logic [AW-1:0] raddr_i,
   output logic [DW-1:0] rdata_o
);

   logic [DW-1:0] mem_q [2**AW];
   logic [DW-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   // Output register holds between reads; array itself is never cleared.
   always_ff @(posedge clk_i) begin
      if (!rst_ni)   rdata_q <= '0;
      else if (re_i) rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/framebuf_pp.sv
// Ping-pong frame buffer: RX fills one bank while TX drains the other.
// Define FRAMEBUF_PP_MIRROR_EN to enable per-frame horizontal mirroring.
module framebuf_pp
   import framebuf_pkg::*;
#(
   parameter int IMG_W    = DEF_IMG_W,
   parameter int IMG_H    = DEF_IMG_H,
   parameter int CHANNELS = DEF_CHANNELS,
   parameter int PIX_W    = DEF_PIX_W,
   localparam int PIXELS  = IMG_W * IMG_H,
   localparam int ADDR_W  = $clog2(PIXELS),
   localparam int BUS_W   = CHANNELS * PIX_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [BUS_W-1:0]  pixel_in,
   output logic              receiv_req,
   input  logic              receiv_ack,
   output logic [BUS_W-1:0]  pixel_out,
   output logic              pixel_out_valid,
   input  logic              send_req,
   output logic              send_ack,
   input  logic              mirror_h,
   output logic [1:0]        bank_full,
   output logic [1:0]        rx_state,
   output logic [1:0]        tx_state,
   output logic [ADDR_W-1:0] rx_addr,
   output logic [ADDR_W-1:0] tx_addr
);

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(PIXELS - 1);
   localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

   rx_state_e         rx_state_q, rx_state_d;
   tx_state_e         tx_state_q, tx_state_d;
   logic [ADDR_W-1:0] rx_addr_q, rx_addr_d;
   logic [ADDR_W-1:0] tx_addr_q, tx_addr_d;
   logic              rx_bank_q, rx_bank_d;
   logic              tx_bank_q, tx_bank_d;
   logic [1:0]        full_q, full_d;
   logic              valid_q;
   logic              wr_en, rx_last, tx_last;
   logic [ADDR_W-1:0] rd_addr;

   assign receiv_req = (rx_state_q == RX_IDLE) && !full_q[rx_bank_q];

   always_comb begin
      send_ack = 1'b0;
      unique case (tx_state_q)
         TX_IDLE:   send_ack = send_req && full_q[tx_bank_q];
         TX_ACTIVE: send_ack = send_req;
         default:   send_ack = 1'b0;
      endcase
   end

   always_comb begin
      rx_state_d = rx_state_q;
      rx_addr_d  = rx_addr_q;
      rx_bank_d  = rx_bank_q;
      wr_en      = 1'b0;
      rx_last    = 1'b0;
      unique case (rx_state_q)
         RX_IDLE:   wr_en = receiv_req && receiv_ack;
         RX_ACTIVE: wr_en = receiv_ack;
         RX_DONE:   if (!receiv_ack) rx_state_d = RX_IDLE;
         default:   rx_state_d = RX_IDLE;
      endcase
      if (wr_en) begin
         if (rx_addr_q == LAST) begin
            rx_last    = 1'b1;
            rx_addr_d  = '0;
            rx_bank_d  = ~rx_bank_q;
            rx_state_d = RX_DONE;
         end else begin
            rx_addr_d  = rx_addr_q + ONE;
            rx_state_d = RX_ACTIVE;
         end
      end
   end

   always_comb begin
      tx_state_d = tx_state_q;
      tx_addr_d  = tx_addr_q;
      tx_bank_d  = tx_bank_q;
      tx_last    = 1'b0;
      if (send_ack) begin
         if (tx_addr_q == LAST) begin
            tx_last    = 1'b1;
            tx_addr_d  = '0;
            tx_bank_d  = ~tx_bank_q;
            tx_state_d = TX_DONE;
         end else begin
            tx_addr_d  = tx_addr_q + ONE;
            tx_state_d = TX_ACTIVE;
         end
      end else if (tx_state_q == TX_DONE && !send_req) begin
         tx_state_d = TX_IDLE;
      end else if (tx_state_q != TX_ACTIVE && tx_state_q != TX_DONE) begin
         tx_state_d = TX_IDLE;
      end
   end

   // RX and TX always own different banks, so set and clear never collide.
   always_comb begin
      full_d = full_q;
      if (rx_last) full_d[rx_bank_q] = 1'b1;
      if (tx_last) full_d[tx_bank_q] = 1'b0;
   end

`ifdef FRAMEBUF_PP_MIRROR_EN
   logic mirror_q;
   logic mir_eff;

   // First read of a frame happens in IDLE, before mirror_q is loaded.
   assign mir_eff = (tx_state_q == TX_IDLE) ? mirror_h : mirror_q;
   assign rd_addr = mir_eff
                  ? ADDR_W'(mirror_idx(32'(tx_addr_q), IMG_W))
                  : tx_addr_q;

   always_ff @(posedge clk) begin
      if (!reset)
         mirror_q <= 1'b0;
      else if (tx_state_q == TX_IDLE && send_ack)
         mirror_q <= mirror_h;
   end
`else
   logic unused_mirror;
   assign unused_mirror = mirror_h;
   assign rd_addr       = tx_addr_q;
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         rx_state_q <= RX_IDLE;
         tx_state_q <= TX_IDLE;
         rx_addr_q  <= '0;
         tx_addr_q  <= '0;
         rx_bank_q  <= 1'b0;
         tx_bank_q  <= 1'b0;
         full_q     <= '0;
         valid_q    <= 1'b0;
      end else begin
         rx_state_q <= rx_state_d;
         tx_state_q <= tx_state_d;
         rx_addr_q  <= rx_addr_d;
         tx_addr_q  <= tx_addr_d;
         rx_bank_q  <= rx_bank_d;
         tx_bank_q  <= tx_bank_d;
         full_q     <= full_d;
         valid_q    <= send_ack;
      end
   end

   framebuf_pp_mem #(
      .AW (ADDR_W + 1),
      .DW (BUS_W)
   ) u_mem (
      .clk_i   (clk),
      .rst_ni  (reset),
      .we_i    (wr_en),
      .waddr_i ({rx_bank_q, rx_addr_q}),
      .wdata_i (pixel_in),
      .re_i    (send_ack),
      .raddr_i ({tx_bank_q, rd_addr}),
      .rdata_o (pixel_out)
   );

   assign pixel_out_valid = valid_q;
   assign bank_full       = full_q;
   assign rx_state        = rx_state_q;
   assign tx_state        = tx_state_q;
   assign rx_addr         = rx_addr_q;
   assign tx_addr         = tx_addr_q;

endmodule
